// File: rtl/multiplicador_booth_seq.sv
// Self-sequenced radix-2 Booth multiplier with start/ready/valid handshake.
// An internal FSM and iteration counter drive the add/sub/shift datapath;
// the product is registered on the final step and held until the next result.
// Optional build macro: MULT_UNSIGNED_MODE_EN adds a sign_mode input
// (1 = signed, 0 = unsigned operands, one extra iteration).
module multiplicador_booth_seq #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef MULT_UNSIGNED_MODE_EN
  input  logic             sign_mode,
`endif
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic             ready,
  output logic             valid,
  output logic [2*N-1:0]   Y,
  output logic [1:0]       Q_LSB
);

  localparam int unsigned YW = 2 * N;
  localparam int unsigned HW = N + 1;
`ifdef MULT_UNSIGNED_MODE_EN
  localparam int unsigned CW = $clog2(N + 2);
`else
  localparam int unsigned CW = $clog2(N + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [HW-1:0]   m_q;
  logic [HW-1:0]   hq_q;
  logic [N-1:0]    lq_q;
  logic            q1_q;
  logic [CW-1:0]   count_q;

  logic [1:0]      pair_c;
  logic [HW-1:0]   hq_sum_c;
  logic [HW-1:0]   hq_nxt_c;
  logic [N-1:0]    lq_nxt_c;
  logic            q1_nxt_c;
  logic [YW-1:0]   y_nxt_c;
  logic            last_step_c;
  logic            force_zero_c;
  logic [HW-1:0]   m_load_c;
  logic [CW-1:0]   count_load_c;

`ifdef MULT_UNSIGNED_MODE_EN
  logic            unsigned_q;
`endif

  assign last_step_c = (count_q == CW'(1));

  // Handshake and debug outputs decoded straight from registers.
  assign ready = (state_q != S_CALC);
  assign Q_LSB = {lq_q[0], q1_q};

`ifdef MULT_UNSIGNED_MODE_EN
  // The extra unsigned step sees the zero-extension bit of B, not the shifted-in HQ bit.
  assign force_zero_c = unsigned_q && last_step_c;
`else
  assign force_zero_c = 1'b0;
`endif

  // Operand and iteration-count values captured on an accepted start.
  always_comb begin
    m_load_c     = {A[N-1], A};
    count_load_c = CW'(N);
`ifdef MULT_UNSIGNED_MODE_EN
    if (!sign_mode) begin
      m_load_c     = {1'b0, A};
      count_load_c = CW'(N + 1);
    end
`endif
  end

  // One Booth step: conditional add/sub of M then arithmetic right shift of {HQ,LQ,Q_1}.
  always_comb begin
    pair_c   = {lq_q[0] & ~force_zero_c, q1_q};
    hq_sum_c = hq_q;
    case (pair_c)
      2'b01:   hq_sum_c = hq_q + m_q;
      2'b10:   hq_sum_c = hq_q - m_q;
      default: hq_sum_c = hq_q;
    endcase
    hq_nxt_c = {hq_sum_c[HW-1], hq_sum_c[HW-1:1]};
    lq_nxt_c = {hq_sum_c[0], lq_q[N-1:1]};
    q1_nxt_c = lq_q[0];
  end

  // Product alignment after the final step; the unsigned run shifts once more.
  always_comb begin
    y_nxt_c = {hq_nxt_c[N-1:0], lq_nxt_c};
`ifdef MULT_UNSIGNED_MODE_EN
    if (unsigned_q) begin
      y_nxt_c = {hq_nxt_c[N-2:0], lq_nxt_c, q1_nxt_c};
    end
`endif
  end

  // Control FSM, datapath registers and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      hq_q       <= '0;
      lq_q       <= '0;
      q1_q       <= 1'b0;
      count_q    <= '0;
      valid      <= 1'b0;
      Y          <= '0;
`ifdef MULT_UNSIGNED_MODE_EN
      unsigned_q <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            m_q        <= m_load_c;
            hq_q       <= '0;
            lq_q       <= B;
            q1_q       <= 1'b0;
            count_q    <= count_load_c;
`ifdef MULT_UNSIGNED_MODE_EN
            unsigned_q <= ~sign_mode;
`endif
            state_q    <= S_CALC;
          end else begin
            state_q    <= S_IDLE;
          end
        end
        S_CALC: begin
          hq_q    <= hq_nxt_c;
          lq_q    <= lq_nxt_c;
          q1_q    <= q1_nxt_c;
          count_q <= count_q - CW'(1);
          if (last_step_c) begin
            state_q <= S_DONE;
            valid   <= 1'b1;
            Y       <= y_nxt_c;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_booth_seq.sv
// Self-checking bench for multiplicador_booth_seq (N=8): directed and random
// multiplications checked against integer arithmetic, latency, hold and reset.
module tb_multiplicador_booth_seq;

  localparam int unsigned N = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic           sign_mode;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           ready;
  logic           valid;
  logic [2*N-1:0] Y;
  logic [1:0]     Q_LSB;

  int total;
  int bad;
  logic [2*N-1:0] exp_hold;

  multiplicador_booth_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef MULT_UNSIGNED_MODE_EN
    .sign_mode (sign_mode),
`endif
    .A         (A),
    .B         (B),
    .ready     (ready),
    .valid     (valid),
    .Y         (Y),
    .Q_LSB     (Q_LSB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain integer arithmetic, truncated to 2N bits.
  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic sm);
    int sa;
    int sb;
    int p;
    if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'({24'd0, a});
      sb = int'({24'd0, b});
    end
    p = sa * sb;
    return p[2*N-1:0];
  endfunction

  // Issue one multiplication from a ready cycle and check hold, latency and result.
  task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm,
                        input bit disturb, input string tag);
    int lat;
    int exp_lat;
    logic [2*N-1:0] exp_y;
    exp_y   = ref_prod(a, b, sm);
    exp_lat = sm ? N : N + 1;
    chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
    A = a;
    B = b;
    sign_mode = sm;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_qlsb0"}, 32'(Q_LSB), 32'({b[0], 1'b0}));
    lat = 0;
    while (valid !== 1'b1 && lat < 40) begin
      chk({tag, "_hold"}, 32'(Y), 32'(exp_hold));
      if (ready !== 1'b0) chk({tag, "_busy"}, 32'(ready), 32'd0);
      if (disturb && lat == 2) begin
        A = N'($urandom);
        B = N'($urandom);
        sign_mode = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_y"}, 32'(Y), 32'(exp_y));
    chk({tag, "_ready_done"}, 32'(ready), 32'd1);
    exp_hold = exp_y;
  endtask

  // Idle a few cycles, checking the result is held and no valid appears.
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk({tag, "_idle_valid"}, 32'(valid), 32'd0);
      chk({tag, "_idle_y"}, 32'(Y), 32'(exp_hold));
    end
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rs;
    total = 0;
    bad = 0;
    exp_hold = '0;
    rst = 1'b0;
    start = 1'b0;
    sign_mode = 1'b1;
    A = '0;
    B = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_y", 32'(Y), 32'd0);
    chk("rst_qlsb", 32'(Q_LSB), 32'd0);
    rst = 1'b1;
    idle(1, "post_rst");

    do_mul(8'd19, 8'd12, 1'b1, 1'b0, "m19x12");
    chk("m19x12_const", 32'(Y), 32'd228);
    do_mul(8'd25, 8'd31, 1'b1, 1'b0, "b2b25x31");
    chk("b2b_const", 32'(Y), 32'd775);
    idle(2, "gap1");
    do_mul(8'hF9, 8'd5, 1'b1, 1'b0, "neg7x5");
    chk("neg7x5_const", 32'(Y), 32'h0000FFDD);
    do_mul(8'h80, 8'h80, 1'b1, 1'b0, "min_x_min");
    chk("min_x_min_const", 32'(Y), 32'h00004000);
    do_mul(8'h80, 8'h7F, 1'b1, 1'b0, "min_x_max");
    idle(1, "gap2");

    do_mul(8'd100, 8'hC3, 1'b1, 1'b1, "disturb");
    idle(2, "gap3");

    // Abort an operation with reset in the middle of CALC.
    A = 8'd77;
    B = 8'd55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_hold = '0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_y", 32'(Y), 32'd0);
    chk("abort_qlsb", 32'(Q_LSB), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_hold_valid", 32'(valid), 32'd0);
      chk("abort_hold_y", 32'(Y), 32'd0);
    end
    rst = 1'b1;
    idle(12, "after_abort");
    do_mul(8'd3, 8'd4, 1'b1, 1'b0, "m3x4");
    chk("m3x4_const", 32'(Y), 32'd12);

`ifdef MULT_UNSIGNED_MODE_EN
    do_mul(8'd255, 8'd255, 1'b0, 1'b0, "u255x255");
    chk("u255_const", 32'(Y), 32'h0000FE01);
    do_mul(8'd255, 8'd255, 1'b1, 1'b0, "s255x255");
    chk("s255_const", 32'(Y), 32'h00000001);
    do_mul(8'd128, 8'd200, 1'b0, 1'b0, "u128x200");
`endif

    for (int k = 0; k < 40; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
`ifdef MULT_UNSIGNED_MODE_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b1;
`endif
      do_mul(ra, rb, rs, 1'($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), "rand_gap");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplicador_booth_seq.md
Name: multiplicador_booth_seq

Overview:
- Self-sequenced radix-2 Booth multiplier, parametrised in operand width N.
- Successor of the externally-controlled multiplier datapath: absorbs the load/add-sub/shift control into an internal FSM and iteration counter.
- Exposes a start/ready/valid handshake so top-level logic issues whole multiplications instead of micro-operations.
- Result is held stable until the next accepted start.

Parameters:
- N, 8, operand width in bits (N >= 2); product width is 2*N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state.
- start  input  1  request; accepted only in a cycle where ready=1.
- A  input  N  multiplicand, sampled on the accepted start.
- B  input  N  multiplier, sampled on the accepted start.
- ready  output  1  high in IDLE and DONE; block can accept start.
- valid  output  1  one-cycle pulse when Y becomes the new product.
- Y  output  2*N  product {HQ,LQ}; held until the next accepted start.
- Q_LSB  output  2  debug {LQ[0],Q_1}: current Booth decision pair.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; M, HQ, LQ, Q_1 and count cleared; Y=0, Q_LSB=2'b00, valid=0, ready=1.
- Internal registers:
  - M: N+1 bits, sign-extended A.
  - HQ: N+1-bit accumulator, so the most-negative operand cannot overflow.
  - LQ: N bits.
  - Q_1: 1 bit.
  - count: $clog2(N+1) bits.
- IDLE: ready=1. On start=1:
  - M<=sext(A), HQ<=0, LQ<=B, Q_1<=0, count<=N.
  - Go to CALC.
- CALC: ready=0. Each cycle is one Booth step.
  - {LQ[0],Q_1}=01: HQ<=HQ+M; =10: HQ<=HQ-M; 00/11: no add.
  - Then in the same cycle, arithmetic right shift of {HQ,LQ,Q_1} by 1 (HQ MSB replicated).
  - count decrements once per step; after the step that takes count to 0, go to DONE.
- DONE: valid=1 for exactly this one cycle; ready=1.
  - Y = {HQ[N-1:0],LQ}, the exact two's-complement product.
  - start in this cycle is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at cycle t -> valid=1 at cycle t+N+1. Throughput: one product every N+1 cycles.
- start while ready=0 is ignored; A/B changes during CALC have no effect.
- Y changes only at the valid cycle; Y holds its value through IDLE and while a new operation is in CALC.
- Reset asserted mid-CALC: operation aborted, all outputs return to reset values; no valid pulse.
- Q_LSB is combinational from registers; it is 2'b00 in IDLE after reset.

Optional Feature:
- Macro: MULT_UNSIGNED_MODE_EN.
- Defined:
  - Adds input port sign_mode (1 bit), sampled with start.
  - sign_mode=1: signed behaviour as above.
  - sign_mode=0: A and B are zero-extended to N+1 bits and the iteration count is N+1, giving the unsigned product.
  - Y is always the lower 2*N bits; for unsigned operands no truncation occurs.
  - Latency in unsigned mode is N+2 cycles.
- Undefined: no sign_mode port; operands are always signed and latency is fixed at N+1.

Test Plan:
- N=8, A=19, B=12, start pulse -> valid exactly 9 cycles later; Y=16'd228; ready high again.
- A=25, B=31 issued in the DONE cycle of the previous multiplication -> accepted without an IDLE cycle; Y=16'd775 after 9 cycles.
- A=-7 (8'hF9), B=5 -> Y=16'hFFDD (-35). A=-128, B=-128 -> Y=16'h4000 (16384).
- Pulse start again during CALC with different operands -> ignored; the original product is delivered; Y unchanged until valid.
- Drive rst=0 mid-CALC, release, then A=3, B=4 -> outputs 0 during reset; no stray valid; Y=16'd12.
- With MULT_UNSIGNED_MODE_EN: sign_mode=0, A=255, B=255 -> Y=16'hFE01 after 10 cycles. sign_mode=1 with the same operands -> Y=16'h0001.
